// File: rtl/cntlz_pipe.sv
// Pipelined leading/trailing zero/one counter with valid/ready on both sides and 2-cycle latency.
// Optional feature: define CNTLZ_PIPE_POPCNT_EN to add the o_pop population-count output.
module cntlz_pipe #(
  parameter  int unsigned WID = 64,
  localparam int unsigned CW  = $clog2(WID + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_valid,
  output logic           i_ready,
  input  logic [1:0]     i_mode,
  input  logic [WID-1:0] i,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [CW-1:0]  o_cnt,
  output logic           o_all
`ifdef CNTLZ_PIPE_POPCNT_EN
  ,
  output logic [CW-1:0]  o_pop
`endif
);

  localparam int unsigned NB = WID / 8;

  // Leading-zero count of one byte, 0..8
  function automatic logic [3:0] lz8(input logic [7:0] b);
    logic [3:0] n;
    casez (b)
      8'b1???????: n = 4'd0;
      8'b01??????: n = 4'd1;
      8'b001?????: n = 4'd2;
      8'b0001????: n = 4'd3;
      8'b00001???: n = 4'd4;
      8'b000001??: n = 4'd5;
      8'b0000001?: n = 4'd6;
      8'b00000001: n = 4'd7;
      default:     n = 4'd8;
    endcase
    return n;
  endfunction

  logic           adv1, adv2;
  logic           v1_q, v2_q;
  logic [WID-1:0] rev, x;
  logic [NB-1:0][3:0] bcnt_d, bcnt_q;  // index 0 is the most significant byte
  logic [CW-1:0]  cnt_d, cnt_q;
  logic           all_d, all_q;

  // Handshake chain: a stage may load when it is empty or the stage after it is moving
  assign adv2    = !v2_q || o_ready;
  assign adv1    = !v1_q || adv2;
  assign i_ready = adv1 && rst_n;
  assign o_valid = v2_q;
  assign o_cnt   = cnt_q;
  assign o_all   = all_q;

  // Bit-reverse operand for the trailing modes
  always_comb begin
    rev = '0;
    for (int b = 0; b < WID; b++) begin
      rev[b] = i[WID-1-b];
    end
  end

  // Fold all four modes into a leading-zero count of x
  always_comb begin
    x = i_mode[1] ? rev : i;
    if (i_mode[0]) begin
      x = ~x;
    end
  end

  // Per-byte leading-zero counts, MSB byte first
  always_comb begin
    bcnt_d = '0;
    for (int k = 0; k < NB; k++) begin
      bcnt_d[k] = lz8(x[WID-1-8*k -: 8]);
    end
  end

  // Stage 1 register: byte counts plus valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      bcnt_q <= '0;
    end else if (adv1) begin
      v1_q <= i_valid;
      if (i_valid) begin
        bcnt_q <= bcnt_d;
      end
    end
  end

  // Find the first non-full byte from the MSB end and combine its offset with its count
  always_comb begin
    logic found;
    found = 1'b0;
    cnt_d = CW'(WID);
    all_d = 1'b1;
    for (int k = 0; k < NB; k++) begin
      if (!found && (bcnt_q[k] != 4'd8)) begin
        found = 1'b1;
        cnt_d = CW'(8 * k) + CW'(bcnt_q[k]);
        all_d = 1'b0;
      end
    end
  end

  // Stage 2 register: valid follows stage 1; results change only when a valid entry loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q  <= 1'b0;
      cnt_q <= '0;
      all_q <= 1'b0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        cnt_q <= cnt_d;
        all_q <= all_d;
      end
    end
  end

`ifdef CNTLZ_PIPE_POPCNT_EN
  logic [NB-1:0][3:0] bpop_d, bpop_q;
  logic [CW-1:0]      pop_d, pop_q;

  assign o_pop = pop_q;

  // Per-byte popcount of the raw operand, independent of mode
  always_comb begin
    bpop_d = '0;
    for (int k = 0; k < NB; k++) begin
      for (int b = 0; b < 8; b++) begin
        bpop_d[k] = bpop_d[k] + 4'(i[8*k+b]);
      end
    end
  end

  // Stage 1 popcount register, loaded alongside the byte counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bpop_q <= '0;
    end else if (adv1 && i_valid) begin
      bpop_q <= bpop_d;
    end
  end

  // Sum of byte popcounts
  always_comb begin
    pop_d = '0;
    for (int k = 0; k < NB; k++) begin
      pop_d = pop_d + CW'(bpop_q[k]);
    end
  end

  // Stage 2 popcount register, same load condition as o_cnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_q <= '0;
    end else if (adv2 && v1_q) begin
      pop_q <= pop_d;
    end
  end
`endif

endmodule
